// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the WISC pipeline hazard controller:
//               FSM state encoding, default widths and drain length.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int REG_AW_DEFAULT     = 4;
    localparam int HALT_DRAIN_DEFAULT = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        DRAIN    = 2'd2,
        HALT     = 2'd3
    } pipe_state_e;

    // Width needed to hold a drain count of n (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Bundle between the pipeline (master) and the hazard
//               controller (slave): hazard inputs from ID/EX/memories and
//               the write-enable / invalidate controls back to the pipeline.
//               PIPE_HAZ_PERF_EN adds the performance counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = pipe_pkg::REG_AW_DEFAULT
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_halt;
    logic              id_valid;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_branch_taken;
    logic              imem_busy;
    logic              dmem_busy;

    logic              pc_wen;
    logic              ifid_wen;
    logic              ifid_inval;
    logic              idex_wen;
    logic              idex_inval;
    logic              exmem_wen;
    logic              halted;
    logic [1:0]        state_o;
`ifdef PIPE_HAZ_PERF_EN
    logic [15:0]       stall_cycles;
    logic [15:0]       flush_count;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt, id_valid,
               ex_memread, ex_rd, ex_branch_taken, imem_busy, dmem_busy,
`ifdef PIPE_HAZ_PERF_EN
        input  stall_cycles, flush_count,
`endif
        input  pc_wen, ifid_wen, ifid_inval, idex_wen, idex_inval,
               exmem_wen, halted, state_o
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt, id_valid,
               ex_memread, ex_rd, ex_branch_taken, imem_busy, dmem_busy,
`ifdef PIPE_HAZ_PERF_EN
        output stall_cycles, flush_count,
`endif
        output pc_wen, ifid_wen, ifid_inval, idex_wen, idex_inval,
               exmem_wen, halted, state_o
    );

endinterface
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use comparator: flags when the valid
//               instruction in ID reads the destination of a load in EX.
//               Register 0 is compared like any other register.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int REG_AW = 4
) (
    input  wire logic [REG_AW-1:0] id_rs,
    input  wire logic [REG_AW-1:0] id_rt,
    input  wire logic              id_uses_rs,
    input  wire logic              id_uses_rt,
    input  wire logic              id_valid,
    input  wire logic              ex_memread,
    input  wire logic [REG_AW-1:0] ex_rd,
    output logic                   lu
);

    logic w_rs_hit;
    logic w_rt_hit;

    // Per-source match against the load destination, then qualify.
    always_comb begin
        w_rs_hit = id_uses_rs && (id_rs == ex_rd);
        w_rt_hit = id_uses_rt && (id_rt == ex_rd);
        lu       = id_valid && ex_memread && (w_rs_hit || w_rt_hit);
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage WISC pipeline. Drives
//               PC, IF/ID and ID/EX write-enables and bubble inserts, and
//               handles load-use stalls, taken-branch flushes, memory-busy
//               freezes and HLT drain. Optional macro PIPE_HAZ_PERF_EN adds
//               saturating stall_cycles / flush_count counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEFAULT,
    parameter int HALT_DRAIN = HALT_DRAIN_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int CNT_W = cnt_width(HALT_DRAIN);

    pipe_state_e       r_state;
    pipe_state_e       w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_halted;

    logic w_lu;
    logic w_pc_wen;
    logic w_ifid_wen;
    logic w_ifid_inval;
    logic w_idex_wen;
    logic w_idex_inval;
    logic w_exmem_wen;
    logic w_flush;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_rs      (hz.id_rs),
        .id_rt      (hz.id_rt),
        .id_uses_rs (hz.id_uses_rs),
        .id_uses_rt (hz.id_uses_rt),
        .id_valid   (hz.id_valid),
        .ex_memread (hz.ex_memread),
        .ex_rd      (hz.ex_rd),
        .lu         (w_lu)
    );

    // State, drain counter and halted flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_halted <= (w_next == HALT);
        end
    end

    // Next-state and output decode in priority order.
    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_pc_wen     = 1'b0;
        w_ifid_wen   = 1'b0;
        w_ifid_inval = 1'b0;
        w_idex_wen   = 1'b0;
        w_idex_inval = 1'b0;
        w_exmem_wen  = 1'b0;
        w_flush      = 1'b0;

        if (rst) begin
            // Fill IF/ID and ID/EX with bubbles while the PC is held.
            w_ifid_wen   = 1'b1;
            w_ifid_inval = 1'b1;
            w_idex_wen   = 1'b1;
            w_idex_inval = 1'b1;
            w_exmem_wen  = 1'b1;
            w_next       = RUN;
            w_cnt_next   = '0;
        end else if (r_state == HALT) begin
            // Everything frozen until reset.
            w_next = HALT;
        end else if (hz.dmem_busy) begin
            // Full freeze: state and drain counter hold.
            w_next = r_state;
        end else if (hz.ex_branch_taken) begin
            w_pc_wen     = 1'b1;
            w_ifid_wen   = 1'b1;
            w_ifid_inval = 1'b1;
            w_idex_wen   = 1'b1;
            w_idex_inval = 1'b1;
            w_exmem_wen  = 1'b1;
            w_flush      = 1'b1;
            w_next       = RUN;
            w_cnt_next   = '0;
        end else if (r_state == DRAIN) begin
            // HLT is moving through EX/MEM/WB; feed bubbles behind it.
            w_ifid_wen   = 1'b1;
            w_ifid_inval = 1'b1;
            w_idex_wen   = 1'b1;
            w_idex_inval = 1'b1;
            w_exmem_wen  = 1'b1;
            w_cnt_next   = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
            w_next       = (r_cnt <= CNT_W'(1)) ? HALT : DRAIN;
        end else if (hz.imem_busy) begin
            // No fetch this cycle; back end keeps moving.
            w_ifid_wen   = 1'b1;
            w_ifid_inval = 1'b1;
            w_idex_wen   = 1'b1;
            w_exmem_wen  = 1'b1;
            w_idex_inval = w_lu;
            w_next       = w_lu ? LU_STALL : RUN;
        end else if (w_lu) begin
            // Hold PC and IF/ID, bubble into ID/EX for one cycle.
            w_idex_wen   = 1'b1;
            w_idex_inval = 1'b1;
            w_exmem_wen  = 1'b1;
            w_next       = LU_STALL;
        end else if (hz.id_halt) begin
            // HLT passes into ID/EX; nothing new is fetched behind it.
            w_ifid_wen   = 1'b1;
            w_ifid_inval = 1'b1;
            w_idex_wen   = 1'b1;
            w_exmem_wen  = 1'b1;
            w_cnt_next   = CNT_W'(HALT_DRAIN);
            w_next       = DRAIN;
        end else begin
            w_pc_wen     = 1'b1;
            w_ifid_wen   = 1'b1;
            w_idex_wen   = 1'b1;
            w_exmem_wen  = 1'b1;
            w_next       = RUN;
        end
    end

    assign hz.pc_wen     = w_pc_wen;
    assign hz.ifid_wen   = w_ifid_wen;
    assign hz.ifid_inval = w_ifid_inval;
    assign hz.idex_wen   = w_idex_wen;
    assign hz.idex_inval = w_idex_inval;
    assign hz.exmem_wen  = w_exmem_wen;
    assign hz.halted     = r_halted;
    assign hz.state_o    = r_state;

`ifdef PIPE_HAZ_PERF_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    // Saturating counters of PC-hold cycles and taken-branch flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!w_pc_wen && (r_state != HALT) && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (w_flush && (r_flush_count != 16'hFFFF))
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign hz.stall_cycles = r_stall_cycles;
    assign hz.flush_count  = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Scoreboard bench for pipe_hazard_ctrl. Each issued cycle
//               pushes the expected {pc_wen, ifid_wen, ifid_inval, idex_wen,
//               idex_inval, exmem_wen, halted, state_o} into a queue; a
//               monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(4)) hz ();

    pipe_hazard_ctrl #(
        .REG_AW     (4),
        .HALT_DRAIN (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        string      name;
        logic [8:0] exp;
        logic [8:0] mask;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Expected vectors: {pc,ifw,ifi,idw,idi,exw,halted,state[1:0]}
    localparam logic [8:0] RST_P   = 9'b011111_0_00;
    localparam logic [8:0] RUN0    = 9'b110101_0_00;
    localparam logic [8:0] RUN1    = 9'b110101_0_01;
    localparam logic [8:0] STALL0  = 9'b000111_0_00;
    localparam logic [8:0] STALL1  = 9'b000111_0_01;
    localparam logic [8:0] FLUSH0  = 9'b111111_0_00;
    localparam logic [8:0] FLUSH1  = 9'b111111_0_01;
    localparam logic [8:0] FLUSH2  = 9'b111111_0_10;
    localparam logic [8:0] IMEM0   = 9'b011101_0_00;
    localparam logic [8:0] IMEMLU0 = 9'b011111_0_00;
    localparam logic [8:0] HLTIN0  = 9'b011101_0_00;
    localparam logic [8:0] HLTIN1  = 9'b011101_0_01;
    localparam logic [8:0] FRZ0    = 9'b000000_0_00;
    localparam logic [8:0] FRZ2    = 9'b000000_0_10;
    localparam logic [8:0] DRN2    = 9'b011111_0_10;
    localparam logic [8:0] HLT3    = 9'b000000_1_11;
    localparam logic [8:0] ALL     = 9'h1FF;
    localparam logic [8:0] CTRL    = 9'b111111_0_00;

    // Monitor: compare each presented cycle against the scoreboard head.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t        t;
            logic [8:0] act;
            t   = sb_q.pop_front();
            act = {hz.pc_wen, hz.ifid_wen, hz.ifid_inval, hz.idex_wen,
                   hz.idex_inval, hz.exmem_wen, hz.halted, hz.state_o};
            n_tests++;
            if (((act ^ t.exp) & t.mask) != 9'd0) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (mask %b)",
                         t.name, act, t.exp, t.mask);
            end
        end
    end

    task automatic idle_inputs();
        hz.id_rs           = 4'd0;
        hz.id_rt           = 4'd0;
        hz.id_uses_rs      = 1'b0;
        hz.id_uses_rt      = 1'b0;
        hz.id_halt         = 1'b0;
        hz.id_valid        = 1'b0;
        hz.ex_memread      = 1'b0;
        hz.ex_rd           = 4'd0;
        hz.ex_branch_taken = 1'b0;
        hz.imem_busy       = 1'b0;
        hz.dmem_busy       = 1'b0;
    endtask

    task automatic set_lu_rs();
        hz.ex_memread = 1'b1;
        hz.ex_rd      = 4'd4;
        hz.id_rs      = 4'd4;
        hz.id_uses_rs = 1'b1;
        hz.id_valid   = 1'b1;
    endtask

    // Issue one cycle with the current inputs and its expected response.
    task automatic cyc(input string nm, input logic [8:0] e,
                       input logic [8:0] m = 9'h1FF);
        sb_t t;
        t.name = nm;
        t.exp  = e;
        t.mask = m;
        sb_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

`ifdef PIPE_HAZ_PERF_EN
    task automatic chk16(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset flush
        cyc("rst0", RST_P);
        cyc("rst1", RST_P);
        rst = 1'b0;
        cyc("idle_after_rst", RUN0);

        // Load-use on rs
        set_lu_rs();
        cyc("lu_rs", STALL0);
        hz.ex_memread = 1'b0;
        cyc("lu_release", RUN1);
        idle_inputs();
        cyc("idle0", RUN0);

        // Near misses
        set_lu_rs(); hz.id_valid = 1'b0;
        cyc("lu_not_valid", RUN0);
        set_lu_rs(); hz.id_uses_rs = 1'b0;
        cyc("lu_not_used", RUN0);
        set_lu_rs(); hz.id_rs = 4'd5;
        cyc("lu_reg_mismatch", RUN0);
        set_lu_rs(); hz.ex_memread = 1'b0;
        cyc("lu_not_load", RUN0);

        // Load-use on rt, re-stall from LU_STALL
        idle_inputs();
        hz.ex_memread = 1'b1; hz.ex_rd = 4'd7; hz.id_rt = 4'd7;
        hz.id_uses_rt = 1'b1; hz.id_valid = 1'b1;
        cyc("lu_rt", STALL0);
        cyc("lu_restall", STALL1);
        hz.ex_memread = 1'b0;
        cyc("lu_rt_release", RUN1);
        idle_inputs();
        cyc("idle1", RUN0);

        // Branch beats lu and imem_busy
        set_lu_rs(); hz.imem_busy = 1'b1; hz.ex_branch_taken = 1'b1;
        cyc("branch_over_all", FLUSH0);
        hz.imem_busy = 1'b0; hz.ex_branch_taken = 1'b0;
        cyc("lu_after_branch", STALL0);
        hz.ex_branch_taken = 1'b1;
        cyc("branch_from_lustall", FLUSH1);
        idle_inputs();
        cyc("idle2", RUN0);

        // imem_busy alone and with lu
        hz.imem_busy = 1'b1;
        cyc("imem_busy", IMEM0);
        set_lu_rs();
        cyc("imem_busy_lu", IMEMLU0);
        idle_inputs();
        cyc("imem_lu_after", RUN1);
        cyc("idle3", RUN0);

        // dmem freeze in RUN with a pending lu
        set_lu_rs(); hz.dmem_busy = 1'b1;
        cyc("dmem_freeze_run", FRZ0);
        hz.dmem_busy = 1'b0;
        cyc("lu_after_freeze", STALL0);
        idle_inputs();
        cyc("idle4", RUN1);
        cyc("idle5", RUN0);

        // HLT drain with a dmem freeze at counter 2
        hz.id_halt = 1'b1; hz.id_valid = 1'b1;
        cyc("halt_enter", HLTIN0);
        idle_inputs();
        cyc("drain_c3", DRN2);
        hz.dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) cyc("drain_frozen", FRZ2);
        hz.dmem_busy = 1'b0;
        cyc("drain_c2", DRN2);
        cyc("drain_c1", DRN2);
        cyc("halted0", HLT3);
        hz.ex_branch_taken = 1'b1;
        cyc("halted_branch", HLT3);
        hz.ex_branch_taken = 1'b0; set_lu_rs();
        cyc("halted_lu", HLT3);
        idle_inputs();
        cyc("halted1", HLT3);

        // Reset out of HALT
        rst = 1'b1;
        cyc("rst_from_halt", RST_P, CTRL);
        cyc("rst_from_halt2", RST_P);
        rst = 1'b0;
        cyc("run_after_halt", RUN0);

        // lu wins over HLT, HLT taken after the stall, branch exits DRAIN
        set_lu_rs(); hz.id_halt = 1'b1;
        cyc("lu_over_halt", STALL0);
        hz.ex_memread = 1'b0;
        cyc("halt_after_stall", HLTIN1);
        idle_inputs(); hz.ex_branch_taken = 1'b1;
        cyc("branch_from_drain", FLUSH2);
        idle_inputs();
        cyc("idle6", RUN0);

`ifdef PIPE_HAZ_PERF_EN
        rst = 1'b1;
        cyc("perf_rst", RST_P);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_lu_rs();
            cyc("perf_lu", STALL0);
            idle_inputs();
            cyc("perf_lu_rel", RUN1);
        end
        for (int i = 0; i < 3; i++) begin
            hz.ex_branch_taken = 1'b1;
            cyc("perf_branch", FLUSH0);
        end
        idle_inputs();
        cyc("perf_idle", RUN0);
        chk16("stall_cycles_5", hz.stall_cycles, 16'd5);
        chk16("flush_count_3", hz.flush_count, 16'd3);
        hz.dmem_busy = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk16("stall_cycles_sat", hz.stall_cycles, 16'hFFFF);
        idle_inputs();
        set_lu_rs();
        cyc("perf_lu_sat", STALL0);
        chk16("stall_cycles_hold", hz.stall_cycles, 16'hFFFF);
        chk16("flush_count_hold", hz.flush_count, 16'd3);
        idle_inputs();
`endif

        @(negedge clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage WISC pipeline.
- Drives the write-enables and invalidate inputs of the IF/ID and ID/EX pipeline registers, plus the PC write-enable.
- Resolves load-use hazards, taken-branch flushes, memory-busy freezes and HLT drain.
- Sits beside the pipeline registers in the cpu top level; purely a controller, carries no datapath.

Parameters:
- REG_AW, 4, register-specifier width (16 architectural registers)
- HALT_DRAIN, 3, cycles after HLT reaches ID before `halted` asserts (EX/MEM/WB drain)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  REG_AW  source-1 register of the instruction in ID
- id_rt  in  REG_AW  source-2 register of the instruction in ID
- id_uses_rs  in  1  ID instruction reads id_rs
- id_uses_rt  in  1  ID instruction reads id_rt
- id_halt  in  1  valid HLT decoded in ID
- id_valid  in  1  ID slot holds a valid (non-inval) instruction
- ex_memread  in  1  EX instruction is a load
- ex_rd  in  REG_AW  destination register of EX instruction
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- imem_busy  in  1  instruction memory not ready this cycle
- dmem_busy  in  1  data memory not ready this cycle
- pc_wen  out  1  PC register write-enable
- ifid_wen  out  1  IF/ID write-enable
- ifid_inval  out  1  IF_inval value loaded into IF/ID (bubble/flush)
- idex_wen  out  1  ID/EX write-enable
- idex_inval  out  1  bubble inserted into ID/EX
- exmem_wen  out  1  EX/MEM and MEM/WB write-enable
- halted  out  1  processor fully halted
- state_o  out  2  current FSM state, for debug

Behaviour:
- States (2-bit encoding): RUN=0, LU_STALL=1, DRAIN=2, HALT=3.
- Reset: state RUN, drain counter 0. Outputs during reset cycle: pc_wen=0, ifid_wen=1, ifid_inval=1, idex_wen=1, idex_inval=1, exmem_wen=1, halted=0. This flushes the pipeline with bubbles.
- Load-use hazard lu is defined as: id_valid & ex_memread & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)). Register 0 is not special-cased.
- Output priority each cycle, highest first:
  1. dmem_busy: full freeze. pc_wen=ifid_wen=idex_wen=exmem_wen=0, all inval=0. State holds; the drain counter does not advance.
  2. ex_branch_taken: pc_wen=1, ifid_wen=1, ifid_inval=1, idex_wen=1, idex_inval=1, exmem_wen=1. Overrides lu, imem_busy and id_halt; state goes to RUN (also from LU_STALL or DRAIN).
  3. imem_busy: pc_wen=0, ifid_wen=1, ifid_inval=1. The back end continues: idex_wen=1, exmem_wen=1, no hazard stall. A pending lu still applies (rule 4) but with ifid_wen=1 and ifid_inval=1.
  4. RUN & lu: pc_wen=0, ifid_wen=0, idex_wen=1, idex_inval=1; go to LU_STALL.
  5. RUN & id_halt: pc_wen=0, ifid_wen=1, ifid_inval=1; ID/EX passes the HLT; counter loads HALT_DRAIN; go to DRAIN.
  6. RUN otherwise: all wen=1, inval=0.
- LU_STALL: exactly one bubble cycle has been inserted. Next cycle behaves as RUN; lu re-evaluated (may re-stall if a new load is in EX).
- DRAIN: pc_wen=0, ifid_wen=1, ifid_inval=1, idex_inval=1, exmem_wen=1. Counter decrements each non-frozen cycle; at 0 go to HALT.
- HALT: halted=1; all wen=0. Only rst leaves HALT.
- Simultaneous rules:
  - lu and id_halt in the same cycle: lu wins; HLT is re-examined after the stall.
  - Reset overrides all inputs in any state.
- Outputs are combinational from state + inputs; state_o and halted are registered.

Optional Feature:
- Macro PIPE_HAZ_PERF_EN.
- When defined: add outputs stall_cycles[15:0] and flush_count[15:0].
  - stall_cycles increments on any cycle with pc_wen=0 while state!=HALT.
  - flush_count increments on each ex_branch_taken.
  - Both saturate at 16'hFFFF and clear on rst.
- When undefined: ports and counters are absent; other behaviour is identical.

Decomposition:
- Shared package pipe_pkg: state encoding constants (RUN/LU_STALL/DRAIN/HALT), REG_AW default, HALT_DRAIN default.
- One natural sub-module, hazard_detect: the combinational lu comparator, reusable for the forwarding unit.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles → pc_wen=0, ifid_inval=1, idex_inval=1, state_o=0, halted=0; first post-reset cycle with no hazards → all wen=1.
- Load-use: ex_memread=1, ex_rd=4, id_rs=4, id_uses_rs=1, id_valid=1 → one cycle pc_wen=0, ifid_wen=0, idex_inval=1, state_o=1; next cycle with ex_memread=0 → RUN, all wen=1.
- Branch vs. stall: ex_branch_taken=1 together with lu=1 and imem_busy=1 → pc_wen=1, ifid_inval=1, idex_inval=1, state_o=0.
- dmem freeze: dmem_busy=1 for 4 cycles while in DRAIN with counter=2 → all wen=0 and counter held at 2; after release, HALT is reached 2 cycles later.
- Halt: id_halt=1 in RUN → DRAIN for 3 cycles, then halted=1 and pc_wen=0 indefinitely; rst returns to RUN.
- PIPE_HAZ_PERF_EN: 5 load-use stalls and 3 branches → stall_cycles=5, flush_count=3; force stall_cycles to 16'hFFFF and stall again → it stays 16'hFFFF.
